// File: rtl/alu_result_checker.sv
// Sweeps operand vectors through an ALU under test and checks each result
// against a built-in golden model, reporting pass, error count and first failure.
module alu_result_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_VEC       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  ALU_OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] F,
  input  logic        ZF,
  input  logic        OF,
  output logic [2:0]  AB_SW,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [2:0]  first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    FIN
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  ab_q, ab_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  err_q, err_d;
  logic [2:0]  ff_q, ff_d;

  logic [31:0] g;
  logic        gz;
  logic        go;
  logic        mismatch;
  logic [3:0]  err_nxt;

  // Golden ALU, evaluated on whatever op/operands are present this cycle
  always_comb begin
    g = '0;
    unique case (ALU_OP)
      3'b000: g = A & B;
      3'b001: g = A | B;
      3'b010: g = A ^ B;
      3'b011: g = ~(A | B);
      3'b100: g = A + B;
      3'b101: g = A - B;
      3'b110: g = {31'd0, $signed(A) < $signed(B)};
      3'b111: g = B << A[4:0];
    endcase
    gz = (g == 32'd0);
    go = 1'b0;
    if (ALU_OP == 3'b100)
      go = (A[31] == B[31]) && (g[31] != A[31]);
    else if (ALU_OP == 3'b101)
      go = (A[31] != B[31]) && (g[31] != A[31]);
  end

  assign mismatch = ({F, ZF, OF} != {g, gz, go});
  assign err_nxt  = err_q + {3'd0, mismatch};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE,
      FIN:    if (start) state_d = SETTLE;
      SETTLE: if (cnt_q == 4'd0) state_d = CHECK;
      CHECK:  state_d = (ab_q == LAST_VEC) ? FIN : SETTLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    ab_d   = ab_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    ff_d   = ff_q;
    unique case (state_q)
      IDLE,
      FIN: begin
        if (start) begin
          ab_d   = '0;
          err_d  = '0;
          ff_d   = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
          busy_d = 1'b1;
          cnt_d  = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      CHECK: begin
        err_d = err_nxt;
        if (mismatch && err_q == 4'd0) ff_d = ab_q;
        if (ab_q == LAST_VEC) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_nxt == 4'd0);
        end else begin
          ab_d  = ab_q + 3'd1;
          cnt_d = CNT_INIT;
        end
      end
    endcase
  end

  assign AB_SW      = ab_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule
